// File: rtl/ro_puf_if.sv
// Request/result bundle for ro_puf_core: pair select and window in, comparison result out.
interface ro_puf_if #(
    parameter int NUM_RO = 8,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16
);
    localparam int SEL_W = $clog2(NUM_RO);

    logic              start;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [WIN_W-1:0]  window_len;
    logic [NUM_RO-1:0] ro_ext;

    logic              busy;
    logic              done;
    logic              response;
    logic [CNT_W-1:0]  count_a;
    logic [CNT_W-1:0]  count_b;
    logic              tie;
    logic              sat;
    logic              err;

    modport master (
        output start, sel_a, sel_b, window_len, ro_ext,
        input  busy, done, response, count_a, count_b, tie, sat, err
    );

    modport slave (
        input  start, sel_a, sel_b, window_len, ro_ext,
        output busy, done, response, count_a, count_b, tie, sat, err
    );
endinterface

// File: rtl/ro_puf_core.sv
// Ring-oscillator PUF core: runs one selected pair of gated rings for a clk-domain
// window, counts synchronized rising edges of each and reports which ring is faster.
module ro_puf_core #(
    parameter int NUM_RO     = 8,
    parameter int RO_STAGES  = 9,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int EXT_RO     = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    ro_puf_if.slave  bus
);
    localparam int               SEL_W     = $clog2(NUM_RO);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE_CYC - 1);

    if ((RO_STAGES < 3) || ((RO_STAGES % 2) == 0)) begin : g_bad_stages
        $error("ro_puf_core: RO_STAGES must be odd and >= 3");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("ro_puf_core: SETTLE_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_a_q, sel_a_d;
    logic [SEL_W-1:0]   sel_b_q, sel_b_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WIN_W-1:0]   tmr_q, tmr_d;
    logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
    logic [1:0]         sync_a_q, sync_a_d;
    logic [1:0]         sync_b_q, sync_b_d;
    logic               prev_a_q, prev_a_d;
    logic               prev_b_q, prev_b_d;
    logic [CNT_W-1:0]   ca_q, ca_d;
    logic [CNT_W-1:0]   cb_q, cb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               resp_q, resp_d;
    logic               tie_q, tie_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   res_a_q, res_a_d;
    logic [CNT_W-1:0]   res_b_q, res_b_d;

    logic [NUM_RO-1:0]  ro_src;
    logic               edge_a, edge_b;

    // A disabled source always reads 1, so enabling a ring can never fake a rising edge.
    if (EXT_RO != 0) begin : g_ext
        assign ro_src = bus.ro_ext | ~ro_en_q;
    end else begin : g_int
        for (genvar r = 0; r < NUM_RO; r++) begin : g_ring
            // NAND is the first inverting stage; RO_STAGES-1 inverters follow, odd total.
            logic [RO_STAGES-1:0] stg;
            assign stg[0] = ~(ro_en_q[r] & stg[RO_STAGES-1]);
            for (genvar s = 1; s < RO_STAGES; s++) begin : g_inv
                assign stg[s] = ~stg[s-1];
            end
            assign ro_src[r] = stg[RO_STAGES-1];
        end
    end

    assign edge_a = sync_a_q[1] & ~prev_a_q;
    assign edge_b = sync_b_q[1] & ~prev_b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            win_q    <= '0;
            tmr_q    <= '0;
            ro_en_q  <= '0;
            sync_a_q <= '0;
            sync_b_q <= '0;
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
            ca_q     <= '0;
            cb_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= 1'b0;
            tie_q    <= 1'b0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            res_a_q  <= '0;
            res_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            win_q    <= win_d;
            tmr_q    <= tmr_d;
            ro_en_q  <= ro_en_d;
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            prev_a_q <= prev_a_d;
            prev_b_q <= prev_b_d;
            ca_q     <= ca_d;
            cb_q     <= cb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            resp_q   <= resp_d;
            tie_q    <= tie_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            res_a_q  <= res_a_d;
            res_b_q  <= res_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        win_d    = win_q;
        tmr_d    = tmr_q;
        ro_en_d  = ro_en_q;
        sync_a_d = {sync_a_q[0], ro_src[sel_a_q]};
        sync_b_d = {sync_b_q[0], ro_src[sel_b_q]};
        prev_a_d = sync_a_q[1];
        prev_b_d = sync_b_q[1];
        ca_d     = ca_q;
        cb_d     = cb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        resp_d   = resp_q;
        tie_d    = tie_q;
        sat_d    = sat_q;
        err_d    = err_q;
        res_a_d  = res_a_q;
        res_b_d  = res_b_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sel_a_d = bus.sel_a;
                    sel_b_d = bus.sel_b;
                    win_d   = bus.window_len;
                    ca_d    = '0;
                    cb_d    = '0;
                    resp_d  = 1'b0;
                    sat_d   = 1'b0;
                    res_a_d = '0;
                    res_b_d = '0;
                    if ((bus.sel_a == bus.sel_b) || (bus.window_len == '0)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        tie_d   = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        tie_d   = 1'b0;
                        tmr_d   = SETTLE_LD;
                        ro_en_d = '0;
                        ro_en_d[bus.sel_a] = 1'b1;
                        ro_en_d[bus.sel_b] = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = ST_MEASURE;
                    tmr_d   = win_q - WIN_W'(1);
                end else begin
                    tmr_d = tmr_q - WIN_W'(1);
                end
            end
            ST_MEASURE: begin
                if (edge_a && (ca_q != CNT_MAX)) ca_d = ca_q + CNT_W'(1);
                if (edge_b && (cb_q != CNT_MAX)) cb_d = cb_q + CNT_W'(1);
                if (tmr_q == '0) begin
                    // Results capture the last window cycle's increment as well.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ro_en_d = '0;
                    res_a_d = ca_d;
                    res_b_d = cb_d;
                    resp_d  = (ca_d > cb_d);
                    tie_d   = (ca_d == cb_d);
                    sat_d   = (ca_d == CNT_MAX) || (cb_d == CNT_MAX);
                end else begin
                    tmr_d = tmr_q - WIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.response = resp_q;
    assign bus.count_a  = res_a_q;
    assign bus.count_b  = res_b_q;
    assign bus.tie      = tie_q;
    assign bus.sat      = sat_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ro_puf_core.sv
// Scoreboard bench for ro_puf_core in external-oscillator mode; a second instance with
// 4-bit counters covers saturation.
module tb_ro_puf_core;
    localparam int NRO = 8;
    localparam int S   = 4;

    typedef struct {
        string nm;
        int    dcyc;
        int    a_lo, a_hi, b_lo, b_hi;
        int    resp, tie, sat, err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   half[NRO];
    int   gcnt = 0;
    logic [NRO-1:0] ro_v = '0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    ro_puf_if #(.NUM_RO(NRO), .CNT_W(16), .WIN_W(16)) b0 ();
    ro_puf_if #(.NUM_RO(NRO), .CNT_W(4),  .WIN_W(16)) b1 ();

    assign b0.ro_ext = ro_v;
    assign b1.ro_ext = ro_v;

    ro_puf_core #(.NUM_RO(NRO), .RO_STAGES(9), .CNT_W(16), .WIN_W(16),
                  .SETTLE_CYC(S), .EXT_RO(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    ro_puf_core #(.NUM_RO(NRO), .RO_STAGES(9), .CNT_W(4), .WIN_W(16),
                  .SETTLE_CYC(S), .EXT_RO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // External oscillators: bit i toggles every half[i] clk cycles, all from one phase.
    initial forever begin
        @(negedge clk);
        gcnt++;
        for (int i = 0; i < NRO; i++)
            ro_v[i] = (half[i] == 0) ? 1'b0 : (((gcnt / half[i]) % 2) == 1);
    end

    task automatic chk(string nm, int act, int lo, int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic bad(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    task automatic cmp(exp_t e, int dc, int a, int b, int r, int t, int s, int er, int bz);
        chk({e.nm, ".done_cyc"}, dc, e.dcyc, e.dcyc);
        chk({e.nm, ".count_a"}, a, e.a_lo, e.a_hi);
        chk({e.nm, ".count_b"}, b, e.b_lo, e.b_hi);
        chk({e.nm, ".response"}, r, e.resp, e.resp);
        chk({e.nm, ".tie"}, t, e.tie, e.tie);
        chk({e.nm, ".sat"}, s, e.sat, e.sat);
        chk({e.nm, ".err"}, er, e.err, e.err);
        chk({e.nm, ".busy_at_done"}, bz, 0, 0);
    endtask

    // Monitors: pop an expectation whenever a DUT presents done.
    initial forever begin
        @(negedge clk);
        if (rst_n && b0.done) begin
            if (q0.size() == 0) bad("dut0.unexpected_done");
            else cmp(q0.pop_front(), cyc, int'(b0.count_a), int'(b0.count_b), int'(b0.response),
                     int'(b0.tie), int'(b0.sat), int'(b0.err), int'(b0.busy));
        end
        if (rst_n && b1.done) begin
            if (q1.size() == 0) bad("dut1.unexpected_done");
            else cmp(q1.pop_front(), cyc, int'(b1.count_a), int'(b1.count_b), int'(b1.response),
                     int'(b1.tie), int'(b1.sat), int'(b1.err), int'(b1.busy));
        end
    end

    task automatic go(int d, string nm, int sa, int sb, int win, int alo, int ahi, int blo,
                      int bhi, int r, int t, int s, int e, bit push);
        exp_t x;
        @(negedge clk);
        if (d == 0) begin
            b0.sel_a = 3'(sa); b0.sel_b = 3'(sb); b0.window_len = 16'(win); b0.start = 1'b1;
        end else begin
            b1.sel_a = 3'(sa); b1.sel_b = 3'(sb); b1.window_len = 16'(win); b1.start = 1'b1;
        end
        x.nm = nm;  x.dcyc = cyc + 1 + ((e != 0) ? 0 : S + win);
        x.a_lo = alo; x.a_hi = ahi; x.b_lo = blo; x.b_hi = bhi;
        x.resp = r; x.tie = t; x.sat = s; x.err = e;
        if (push) begin
            if (d == 0) q0.push_back(x);
            else q1.push_back(x);
        end
        @(negedge clk);
        // Scramble request inputs; latched values must be unaffected.
        if (d == 0) begin
            b0.start = 1'b0; b0.sel_a = 3'(sa + 3); b0.sel_b = 3'(sa + 3); b0.window_len = 16'd3;
            if (e == 0) begin
                chk({nm, ".busy_t1"}, int'(b0.busy), 1, 1);
                chk({nm, ".err_t1"}, int'(b0.err), 0, 0);
            end
        end else begin
            b1.start = 1'b0; b1.sel_a = 3'(sa + 3); b1.sel_b = 3'(sa + 3); b1.window_len = 16'd3;
            if (e == 0) chk({nm, ".busy_t1"}, int'(b1.busy), 1, 1);
        end
    endtask

    task automatic wait_done(int d, string nm, int budget);
        int k = 0;
        while (((d == 0) ? b0.done : b1.done) == 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, ".done_seen"}, int'((d == 0) ? b0.done : b1.done), 1, 1);
    endtask

    initial begin
        for (int i = 0; i < NRO; i++) half[i] = 0;
        b0.start = 1'b0; b0.sel_a = '0; b0.sel_b = '0; b0.window_len = '0;
        b1.start = 1'b0; b1.sel_a = '0; b1.sel_b = '0; b1.window_len = '0;
        repeat (3) @(negedge clk);
        chk("reset.outputs0", int'({b0.busy, b0.done, b0.response, b0.tie, b0.sat, b0.err}), 0, 0);
        chk("reset.counts0", int'(b0.count_a) + int'(b0.count_b), 0, 0);
        chk("reset.ro_en0", int'(dut0.ro_en_q), 0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle.ro_en0", int'(dut0.ro_en_q), 0, 0);

        // Period 4 vs period 6 over 120 cycles: 30 vs 20 edges.
        half[2] = 2; half[5] = 3;
        go(0, "p4v6", 2, 5, 120, 29, 31, 19, 21, 1, 0, 0, 0, 1);
        chk("p4v6.ro_en_pair", int'(dut0.ro_en_q), 8'h24, 8'h24);
        wait_done(0, "p4v6", 200);
        repeat (3) @(negedge clk);
        chk("p4v6.held_count_a", int'(b0.count_a), 29, 31);
        chk("p4v6.held_response", int'(b0.response), 1, 1);
        chk("p4v6.ro_en_off", int'(dut0.ro_en_q), 0, 0);

        go(0, "swap", 5, 2, 120, 19, 21, 29, 31, 0, 0, 0, 0, 1);
        wait_done(0, "swap", 200);

        // Identical period-8 waveforms on both rings: exact tie.
        half[2] = 4; half[5] = 4;
        go(0, "tie8", 2, 5, 64, 7, 9, 7, 9, 0, 1, 0, 0, 1);
        wait_done(0, "tie8", 200);

        go(0, "same_sel", 3, 3, 50, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("same_sel.no_enable", int'(dut0.ro_en_q), 0, 0);
        wait_done(0, "same_sel", 10);
        repeat (3) @(negedge clk);
        chk("same_sel.err_held", int'(b0.err), 1, 1);
        chk("same_sel.busy_idle", int'(b0.busy), 0, 0);

        go(0, "win0", 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        wait_done(0, "win0", 10);

        // Legal start clears err; repeated start during the run is ignored.
        go(0, "restart", 2, 5, 40, 4, 6, 4, 6, 0, 1, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b0.start = (i % 2 == 0); b0.sel_a = 3'd0; b0.sel_b = 3'd1; b0.window_len = 16'd5;
        end
        @(negedge clk);
        b0.start = 1'b0;
        wait_done(0, "restart", 100);
        b0.start = 1'b1;
        @(negedge clk);
        chk("done_start.busy", int'(b0.busy), 0, 0);
        chk("done_start.done", int'(b0.done), 0, 0);
        b0.start = 1'b0;
        @(negedge clk);
        chk("done_start.not_queued", int'(b0.busy), 0, 0);

        // 4-bit counters: period 2 gives 32 edges, must stick at 15.
        half[0] = 1; half[1] = 4;
        go(1, "sat", 0, 1, 64, 15, 15, 7, 9, 1, 0, 1, 0, 1);
        wait_done(1, "sat", 200);

        // Reset during MEASURE: no result reported.
        half[2] = 2; half[5] = 3;
        go(0, "rst_mid", 2, 5, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (S + 20) @(negedge clk);
        chk("rst_mid.busy_before", int'(b0.busy), 1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid.busy", int'(b0.busy), 0, 0);
        chk("rst_mid.outputs0", int'({b0.done, b0.response, b0.tie, b0.sat, b0.err}), 0, 0);
        chk("rst_mid.counts0", int'(b0.count_a) + int'(b0.count_b), 0, 0);
        chk("rst_mid.ro_en0", int'(dut0.ro_en_q), 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);

        chk("q0.empty", q0.size(), 0, 0);
        chk("q1.empty", q1.size(), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ro_puf_core.md
Name: ro_puf_core

Overview:
- Parametrised ring-oscillator PUF core, the successor to the fixed 9-stage NAND-gated ring.
- Holds NUM_RO gated rings of RO_STAGES inverters each, built from INV and NAND cells as the existing single-ring oscillator is.
- On request it enables one selected pair of rings, counts their rising edges over a programmable window in the clk domain, and produces one response bit from comparing the two counts.
- Sits between the RO array and the key-generation / helper-data logic of the root of trust.

Parameters:
- NUM_RO, 8, number of rings; power of two, at least 2.
- RO_STAGES, 9, inverters per ring; must be odd and at least 3; the NAND gate closes the loop.
- CNT_W, 16, width of each edge counter.
- WIN_W, 16, width of window_len.
- SETTLE_CYC, 4, clk cycles rings run before counting starts; at least 1.
- EXT_RO, 0, 1 = count ro_ext bits instead of internal rings; for verification and FPGA bring-up.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  measurement request; sampled only in IDLE
- sel_a  in  log2(NUM_RO)  index of first ring
- sel_b  in  log2(NUM_RO)  index of second ring
- window_len  in  WIN_W  measurement window in clk cycles
- ro_ext  in  NUM_RO  external oscillator inputs; used only when EXT_RO=1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; results valid
- response  out  1  1 when count_a > count_b
- count_a  out  CNT_W  edge count of ring sel_a
- count_b  out  CNT_W  edge count of ring sel_b
- tie  out  1  count_a == count_b
- sat  out  1  either counter saturated
- err  out  1  illegal request

Interface (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Behaviour:
- Reset: all outputs 0. State IDLE. All ring enables 0. Synchronizers and edge-detect flops 0. Latched selects and window cleared.
- Ring gating: only rings sel_a and sel_b are enabled, and only in SETTLE and MEASURE. A disabled ring's NAND output is held at 1. Ring enables are registered outputs.
- Synchronization: each selected ring output passes through a 2-flop synchronizer and then a rising-edge detector (sync AND NOT prev).
  - A ring period must exceed 2 clk periods for exact counts.
  - Faster rings undercount. This is a characterisation limit, not an error.
- Start acceptance: start high in IDLE at cycle t latches sel_a, sel_b and window_len and clears both counters. Inputs may change afterwards without effect.
- Illegal request: if sel_a == sel_b or window_len == 0:
  - go to DONE at t+1 with err=1, counts 0, response 0, tie 1, sat 0;
  - no ring is enabled.
- FSM:
  - IDLE -> SETTLE on a legal start; busy=1 from t+1.
  - SETTLE lasts SETTLE_CYC cycles; no counting.
  - MEASURE lasts window_len cycles; each detected edge increments its counter.
  - DONE lasts 1 cycle, then IDLE.
  - done=1 at cycle t+1+SETTLE_CYC+window_len; busy=0 in that cycle.
- Counters saturate at 2^CNT_W-1 and never wrap. sat = either counter at its maximum at DONE.
- Result outputs (response, tie, sat, err, counts) are registered in DONE and held until the next start is accepted.
  - response = (count_a > count_b); on a tie, response = 0 and tie = 1.
  - err clears on the next legal start.
- start in any state other than IDLE is ignored; it is not queued. start in the DONE cycle is ignored.
- rst_n low in any state (including mid-MEASURE) returns everything to the reset values on the next clk edge. No partial result is reported.
- The RO loops are the only combinational cycles in the block and are excluded from timing. The clk port does not drive any ring.

Test Plan:
- EXT_RO=1, sel_a=2, sel_b=5, ro_ext[2] period 4 clk, ro_ext[5] period 6 clk, window_len=120 -> done at t+1+4+120, count_a=30±1, count_b=20±1, response=1, tie=0, sat=0, err=0.
- Same setup with sel_a/sel_b swapped -> response=0; then both rings at period 8, window 64 -> counts 8±1; if counts are equal, tie=1 and response=0.
- sel_a=sel_b=3, start -> done at t+1, err=1, counts 0, response 0; the next legal start clears err.
- CNT_W=4, period 2 clk, window_len=64 -> count_a=15, sat=1, no wrap.
- start pulsed repeatedly during MEASURE -> ignored, single done pulse; rst_n low mid-MEASURE -> next cycle busy=0, outputs 0, enables 0, no done.
- EXT_RO=0 with cell delays, sel 0/1, window 1000 -> nonzero counts, only rings 0 and 1 toggle, others held at 1.
